auto_player: RTL and testbench

- Upstream auto-play stage of the piano. Reads a song from an internal note ROM and drives the auto-mode speaker square wave and the note LEDs.
- It feeds the auto-mode `speaker1` and `led1` inputs of the output signal selector, and shares `song_num` with that selector.
- Plays one of four stored songs, note by note, with a fixed articulation gap between notes. Supports pause and abort.

---
 rtl/auto_player.sv | 269 ++++++++++++++++++++++++++
 tb/tb_auto_player.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_player.sv
// Auto-play stage: walks a song in the internal note ROM and produces the
// tone square wave, the note LEDs and the playing/done status.
// Handshake: start is a one-cycle request taken whenever en is high (no ready);
// done is a one-cycle pulse with no back-pressure; en low aborts at once.
module auto_player #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned UNIT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000,
  parameter int unsigned SONG_LEN    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] song_num,
  output logic       speaker,
  output logic [7:0] led,
  output logic       playing,
  output logic       done
);

  localparam int AW     = $clog2(SONG_LEN);
  localparam int ADDR_W = AW + 1;

  // Mid-octave half-periods in clock cycles (truncated).
  localparam int unsigned HP_1 = CLK_FREQ / (2 * 262);
  localparam int unsigned HP_2 = CLK_FREQ / (2 * 294);
  localparam int unsigned HP_3 = CLK_FREQ / (2 * 330);
  localparam int unsigned HP_4 = CLK_FREQ / (2 * 349);
  localparam int unsigned HP_5 = CLK_FREQ / (2 * 392);
  localparam int unsigned HP_6 = CLK_FREQ / (2 * 440);
  localparam int unsigned HP_7 = CLK_FREQ / (2 * 494);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          song_q, song_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         dur_cnt_q, dur_cnt_d;
  logic [31:0]         gap_cnt_q, gap_cnt_d;
  logic [19:0]         tone_cnt_q, tone_cnt_d;
  logic [19:0]         half_q, half_d;
  logic                rest_q, rest_d;
  logic                tone_q, tone_d;
  logic                speaker_q, speaker_d;
  logic [7:0]          led_q, led_d;
  logic                playing_q, playing_d;
  logic                done_q, done_d;

  // Word layout: {octave[1:0], note[3:0], duration[2:0]}; duration 0 ends the song.
  function automatic logic [8:0] rom_lookup(input logic [1:0] song, input logic [AW-1:0] idx);
    logic [8:0] w;
    w = 9'd0;
    case (song)
      2'd0: case (int'(idx))
        0: w = 9'b10_0001_001;
        1: w = 9'b01_0011_001;
        2: w = 9'b01_0000_001;
        3: w = 9'b00_0101_001;
        4: w = 9'b11_0010_001;
        5: w = 9'b01_1001_001;
        default: w = 9'd0;
      endcase
      2'd1: case (int'(idx))
        0: w = 9'b01_0101_010;
        1: w = 9'b01_0011_001;
        2: w = 9'b01_0001_100;
        default: w = 9'd0;
      endcase
      2'd2: case (int'(idx))
        0: w = 9'b00_0001_010;
        1: w = 9'b10_0111_001;
        2: w = 9'b01_0000_001;
        3: w = 9'b01_0100_011;
        default: w = 9'd0;
      endcase
      default: case (int'(idx))
        0: w = 9'b01_0001_010;
        1: w = 9'b01_0010_010;
        2: w = 9'b01_0011_010;
        3: w = 9'b01_0100_010;
        4: w = 9'b01_0101_010;
        5: w = 9'b01_0110_010;
        6: w = 9'b01_0111_010;
        default: w = 9'd0;
      endcase
    endcase
    return w;
  endfunction

  logic [8:0]  rom_word;
  logic [1:0]  rom_oct;
  logic [3:0]  rom_note;
  logic [2:0]  rom_dur;
  logic        rom_is_rest;
  logic [19:0] base_hp;
  logic [19:0] rom_half;
  logic [7:0]  rom_led;
  logic [31:0] dur_load;

  // Decode the ROM entry at the current address into tone, LED and duration.
  always_comb begin
    rom_word    = rom_lookup(song_q, addr_q[AW-1:0]);
    rom_oct     = rom_word[8:7];
    rom_note    = rom_word[6:3];
    rom_dur     = rom_word[2:0];
    rom_is_rest = (rom_note == 4'd0) || rom_note[3];
    case (rom_note[2:0])
      3'd1:    base_hp = 20'(HP_1);
      3'd2:    base_hp = 20'(HP_2);
      3'd3:    base_hp = 20'(HP_3);
      3'd4:    base_hp = 20'(HP_4);
      3'd5:    base_hp = 20'(HP_5);
      3'd6:    base_hp = 20'(HP_6);
      3'd7:    base_hp = 20'(HP_7);
      default: base_hp = 20'd0;
    endcase
    case (rom_oct)
      2'b00:   rom_half = {base_hp[18:0], 1'b0};
      2'b10:   rom_half = {1'b0, base_hp[19:1]};
      default: rom_half = base_hp;
    endcase
    rom_led  = rom_is_rest ? 8'd0
             : ((8'd1 << (rom_note[2:0] - 3'd1)) | {rom_oct == 2'b10, 7'd0});
    dur_load = 32'(rom_dur) * UNIT_CYCLES - GAP_CYCLES;
  end

  // Next-state and next-output logic for the player FSM.
  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    addr_d     = addr_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tone_cnt_d = tone_cnt_q;
    half_d     = half_q;
    rest_d     = rest_q;
    tone_d     = tone_q;
    speaker_d  = speaker_q;
    led_d      = led_q;
    case (state_q)
      S_IDLE: begin
        speaker_d = 1'b0;
        led_d     = 8'd0;
        if (en && start) begin
          song_d  = song_num;
          addr_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (rom_dur == 3'd0 || addr_q == ADDR_W'(SONG_LEN)) begin
          state_d = S_DONE;
        end else begin
          dur_cnt_d  = dur_load;
          half_d     = rom_half;
          rest_d     = rom_is_rest;
          tone_cnt_d = 20'd0;
          tone_d     = 1'b0;
          speaker_d  = 1'b0;
          led_d      = rom_led;
          state_d    = S_PLAY;
        end
      end
      S_PLAY: begin
        if (pause) begin
          speaker_d = 1'b0;
        end else begin
          if (!rest_q && tone_cnt_q == half_q - 20'd1) begin
            tone_cnt_d = 20'd0;
            tone_d     = ~tone_q;
          end else begin
            tone_cnt_d = tone_cnt_q + 20'd1;
          end
          speaker_d = tone_d;
          if (dur_cnt_q == 32'd1) begin
            gap_cnt_d = 32'(GAP_CYCLES - 1);
            speaker_d = 1'b0;
            led_d     = 8'd0;
            state_d   = S_GAP;
          end else begin
            dur_cnt_d = dur_cnt_q - 32'd1;
          end
        end
      end
      S_GAP: begin
        speaker_d = 1'b0;
        led_d     = 8'd0;
        if (!pause) begin
          if (gap_cnt_q == 32'd0) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_LOAD;
          end else begin
            gap_cnt_d = gap_cnt_q - 32'd1;
          end
        end
      end
      S_DONE: begin
        speaker_d = 1'b0;
        led_d     = 8'd0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A new start while a song is in progress restarts from the top.
    if (en && start && (state_q == S_LOAD || state_q == S_PLAY || state_q == S_GAP)) begin
      song_d     = song_num;
      addr_d     = '0;
      tone_cnt_d = 20'd0;
      tone_d     = 1'b0;
      speaker_d  = 1'b0;
      led_d      = 8'd0;
      state_d    = S_LOAD;
    end
    // Leaving auto mode wins over everything, and never pulses done.
    if (!en) begin
      addr_d     = '0;
      dur_cnt_d  = 32'd0;
      gap_cnt_d  = 32'd0;
      tone_cnt_d = 20'd0;
      tone_d     = 1'b0;
      speaker_d  = 1'b0;
      led_d      = 8'd0;
      state_d    = S_IDLE;
    end
    playing_d = (state_d == S_LOAD) || (state_d == S_PLAY) || (state_d == S_GAP);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      song_q     <= 2'd0;
      addr_q     <= '0;
      dur_cnt_q  <= 32'd0;
      gap_cnt_q  <= 32'd0;
      tone_cnt_q <= 20'd0;
      half_q     <= 20'd0;
      rest_q     <= 1'b0;
      tone_q     <= 1'b0;
      speaker_q  <= 1'b0;
      led_q      <= 8'd0;
      playing_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      addr_q     <= addr_d;
      dur_cnt_q  <= dur_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      half_q     <= half_d;
      rest_q     <= rest_d;
      tone_q     <= tone_d;
      speaker_q  <= speaker_d;
      led_q      <= led_d;
      playing_q  <= playing_d;
      done_q     <= done_d;
    end
  end

  assign speaker = speaker_q;
  assign led     = led_q;
  assign playing = playing_q;
  assign done    = done_q;

endmodule

// File: tb/tb_auto_player.sv
// Bench for auto_player: a position-in-song model predicts every output each
// cycle, and directed scenarios pin absolute timings by hand.
module tb_auto_player;

  localparam int CLK_FREQ = 100_000;
  localparam int UNIT     = 1000;
  localparam int GAP      = 100;
  localparam int SLEN     = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] song_num = 2'd0;
  logic       speaker;
  logic [7:0] led;
  logic       playing;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;
  int cyc = 0;
  int done_cnt = 0;

  auto_player #(
    .CLK_FREQ(CLK_FREQ), .UNIT_CYCLES(UNIT), .GAP_CYCLES(GAP), .SONG_LEN(SLEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .pause(pause),
    .song_num(song_num), .speaker(speaker), .led(led), .playing(playing), .done(done)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  function automatic int mk(int oct, int nt, int dur);
    return oct * 128 + nt * 8 + dur;
  endfunction

  function automatic int song_word(int s, int i);
    if (s == 3) return (i < 7) ? mk(1, i + 1, 2) : 0;
    if (s == 0) begin
      case (i)
        0: return mk(2, 1, 1);
        1: return mk(1, 3, 1);
        2: return mk(1, 0, 1);
        3: return mk(0, 5, 1);
        4: return mk(3, 2, 1);
        5: return mk(1, 9, 1);
        default: return 0;
      endcase
    end
    return 0;
  endfunction

  function automatic int half_of(int oct, int nt);
    int f;
    int base;
    case (nt)
      1: f = 262; 2: f = 294; 3: f = 330; 4: f = 349;
      5: f = 392; 6: f = 440; 7: f = 494;
      default: f = 0;
    endcase
    if (f == 0) return 0;
    base = CLK_FREQ / (2 * f);
    if (oct == 0) return base * 2;
    if (oct == 2) return base / 2;
    return base;
  endfunction

  function automatic bit is_rest(int nt);
    return (nt == 0) || (nt > 7);
  endfunction

  int m_mode;  // 0 idle, 1 playing a song, 2 done cycle
  int m_song;
  int m_note;
  int m_pos;   // unpaused cycles since the note's load cycle
  bit m_spk;

  function automatic int cur_word();
    if (m_note >= SLEN) return 0;
    return song_word(m_song, m_note);
  endfunction

  // Expected tone level at a given position inside the current note.
  function automatic bit spk_at(int pos);
    int w, oct, nt, dur;
    w = cur_word(); oct = w / 128; nt = (w / 8) % 16; dur = w % 8;
    if (pos < 1 || pos > dur * UNIT - GAP || is_rest(nt)) return 1'b0;
    return (((pos - 1) / half_of(oct, nt)) % 2) == 1;
  endfunction

  function automatic int exp_led();
    int w, oct, nt, dur;
    if (m_mode != 1 || m_pos < 1) return 0;
    w = cur_word(); oct = w / 128; nt = (w / 8) % 16; dur = w % 8;
    if (m_pos > dur * UNIT - GAP || is_rest(nt)) return 0;
    return (1 << (nt - 1)) | ((oct == 2) ? 128 : 0);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_song = 0; m_note = 0; m_pos = 0; m_spk = 1'b0;
  endtask

  task automatic model_step();
    int dur;
    if (m_mode == 2) begin
      m_mode = 0; m_spk = 1'b0;
    end else if (!en) begin
      m_mode = 0; m_spk = 1'b0;
    end else if (start) begin
      m_mode = 1; m_song = int'(song_num); m_note = 0; m_pos = 0; m_spk = 1'b0;
    end else if (m_mode == 1) begin
      dur = cur_word() % 8;
      if (m_pos == 0) begin
        if (dur == 0) m_mode = 2;
        else m_pos = 1;
        m_spk = 1'b0;
      end else if (pause) begin
        m_spk = 1'b0;
      end else begin
        m_pos++;
        if (m_pos > dur * UNIT) begin
          m_note++;
          m_pos = 0;
        end
        m_spk = spk_at(m_pos);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      logic [10:0] act, exp;
      act = {speaker, led, playing, done};
      exp = {m_spk, 8'(exp_led()), m_mode == 1, m_mode == 2};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL model_cmp cyc=%0d: got spk=%0b led=%h play=%0b done=%0b, expected spk=%0b led=%h play=%0b done=%0b",
                   cyc, act[10], act[9:2], act[1], act[0], exp[10], exp[9:2], exp[1], exp[0]);
        end
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] s);
    song_num = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
  endtask

  task automatic wait_led(input logic [7:0] v, input int limit, output int ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (led == v) begin ok = 1; break; end
    end
  endtask

  // ---------------- directed scenarios ----------------
  int t_load, c1, ok, d0, bad_hold;

  initial begin
    step(3);
    check("rst_speaker", int'(speaker), 0);
    check("rst_led", int'(led), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    en = 1'b1;
    step(2);

    // Song 3 first note, tone edges, gap, then completion.
    pulse_start(2'd3);
    t_load = cyc;
    check("s3_load_led", int'(led), 0);
    step(1);
    check("s3_first_led", int'(led), 8'h01);
    check("s3_first_spk", int'(speaker), 0);
    check("s3_playing", int'(playing), 1);
    step(189);
    check("s3_spk_before_rise", int'(speaker), 0);
    step(1);
    check("s3_spk_rise", int'(speaker), 1);
    step(190);
    check("s3_spk_fall", int'(speaker), 0);
    step(1519);
    check("s3_led_last_play", int'(led), 8'h01);
    step(1);
    check("s3_gap_led", int'(led), 0);
    check("s3_gap_spk", int'(speaker), 0);
    step(101);
    check("s3_second_led", int'(led), 8'h02);
    wait_done(20000, ok);
    check("s3_done_seen", ok, 1);
    check("s3_done_time", cyc - t_load, 7 * 2001 + 1);
    step(1);
    check("s3_after_done_playing", int'(playing), 0);
    check("s3_after_done_done", int'(done), 0);
    step(5);
    check("s3_done_count", done_cnt, 1);

    // Pause in note 1 delays note 2 by the paused length.
    pulse_start(2'd3);
    step(1);
    c1 = cyc;
    step(500);
    pause = 1'b1;
    bad_hold = 0;
    for (int i = 0; i < 250; i++) begin
      step(1);
      if (speaker !== 1'b0 || led !== 8'h01) bad_hold++;
    end
    check("pause_hold_bad_cycles", bad_hold, 0);
    pause = 1'b0;
    wait_led(8'h02, 5000, ok);
    check("pause_note2_seen", ok, 1);
    check("pause_note2_time", cyc - c1, 2001 + 250);

    // Abort mid-note.
    step(300);
    d0 = done_cnt;
    en = 1'b0;
    step(1);
    check("abort_spk", int'(speaker), 0);
    check("abort_led", int'(led), 0);
    check("abort_playing", int'(playing), 0);
    step(50);
    check("abort_no_done", done_cnt, d0);
    en = 1'b1;
    step(2);

    // Restart into song 0; later song_num changes are ignored.
    pulse_start(2'd3);
    t_load = cyc;
    step(400);
    pulse_start(2'd0);
    t_load = cyc;
    step(1);
    check("restart_led", int'(led), 8'h81);
    song_num = 2'd2;
    wait_done(10000, ok);
    check("s0_done_seen", ok, 1);
    check("s0_done_time", cyc - t_load, 6 * 1001 + 1);
    step(3);

    // Asynchronous reset mid-note.
    pulse_start(2'd3);
    step(300);
    check("pre_reset_led", int'(led), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_spk", int'(speaker), 0);
    check("async_rst_led", int'(led), 0);
    check("async_rst_playing", int'(playing), 0);
    check("async_rst_done", int'(done), 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("post_reset_idle", int'(playing), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
